// File: rtl/gpio_result_fifo_if.sv
// Bus and result-capture signals shared between the GPIO emulator side and the result FIFO.
// The master modport is the emulator/bus-master side; the slave modport is the FIFO.
interface gpio_result_fifo_if;
  // Result capture from the emulator
  logic        done_pulse;
  logic [31:0] res_word;
  logic [5:0]  res_ones;
  logic        res_valid;

  // 16-bit-address register bus
  logic [15:0] saddress;
  logic        srd;
  logic        swr;
  logic [31:0] sdata_in;
  logic [31:0] sdata_out;

  modport master (
    output done_pulse,
    output res_word,
    output res_ones,
    output res_valid,
    output saddress,
    output srd,
    output swr,
    output sdata_in,
    input  sdata_out
  );

  modport slave (
    input  done_pulse,
    input  res_word,
    input  res_ones,
    input  res_valid,
    input  saddress,
    input  srd,
    input  swr,
    input  sdata_in,
    output sdata_out
  );
endinterface

// File: rtl/gpio_result_fifo.sv
// Result FIFO behind the GPIO multiply/popcount emulator: buffers completed results so software
// can drain them over the register bus, with sticky drop accounting and an interrupt level.
module gpio_result_fifo #(
  parameter int unsigned DEPTH     = 8,
  parameter logic [15:0] ADDR_DATA = 16'h03B0,
  parameter logic [15:0] ADDR_ONES = 16'h03B8,
  parameter logic [15:0] ADDR_STAT = 16'h03C0,
  parameter logic [15:0] ADDR_CTRL = 16'h03C8
) (
  input  logic                     clk,
  input  logic                     reset,
  gpio_result_fifo_if.slave        bus,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     fifo_empty,
  output logic                     fifo_full,
  output logic                     irq
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef struct packed {
    logic        valid;
    logic [5:0]  ones;
    logic [31:0] word;
  } entry_t;

  entry_t          mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            overflow_q, overflow_d;
  logic [7:0]      drop_cnt_q, drop_cnt_d;
  logic            srd_q, swr_q;
  logic [31:0]     sdata_out_q, sdata_out_d;

  logic            empty, full;
  logic            rd_evt, wr_evt;
  logic            pop, push, drop, flush, clr_err;
  entry_t          head;
  entry_t          new_entry;
  logic [7:0]      count_ext;

  assign empty     = (count_q == '0);
  assign full      = (count_q == CW'(DEPTH));
  assign head      = mem_q[rd_ptr_q];
  assign new_entry = '{valid: bus.res_valid, ones: bus.res_ones, word: bus.res_word};
  assign count_ext = 8'(count_q);

  assign rd_evt  = bus.srd & ~srd_q;
  assign wr_evt  = bus.swr & ~swr_q;
  assign flush   = wr_evt & (bus.saddress == ADDR_CTRL) & bus.sdata_in[0];
  assign clr_err = wr_evt & (bus.saddress == ADDR_CTRL) & bus.sdata_in[1];

  // A pop frees a slot in the same cycle, so a full FIFO can still accept a push.
  assign pop  = rd_evt & (bus.saddress == ADDR_ONES) & ~empty & ~flush;
  assign push = bus.done_pulse & (~full | pop) & ~flush;
  assign drop = bus.done_pulse & full & ~pop & ~flush;

  always_comb begin
    sdata_out_d = sdata_out_q;
    if (rd_evt) begin
      sdata_out_d = '0;
      case (bus.saddress)
        ADDR_DATA: if (!empty) sdata_out_d = head.word;
        ADDR_ONES: if (!empty) sdata_out_d = {25'b0, head.valid, head.ones};
        ADDR_STAT: sdata_out_d = {16'b0, drop_cnt_q, 1'b0, overflow_q, full, empty,
                                  count_ext[3:0]};
        default:   sdata_out_d = '0;
      endcase
    end
  end

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    drop_cnt_d = drop_cnt_q;

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      unique case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end

    // Clearing the error state wins over a drop landing in the same cycle.
    if (clr_err) begin
      overflow_d = 1'b0;
      drop_cnt_d = '0;
    end else if (drop) begin
      overflow_d = 1'b1;
      if (drop_cnt_q != 8'hFF) drop_cnt_d = drop_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      drop_cnt_q  <= '0;
      srd_q       <= 1'b0;
      swr_q       <= 1'b0;
      sdata_out_q <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      drop_cnt_q  <= drop_cnt_d;
      srd_q       <= bus.srd;
      swr_q       <= bus.swr;
      sdata_out_q <= sdata_out_d;
    end
  end

  // Storage needs no reset: an entry is only read once count says it was written.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= new_entry;
  end

  assign bus.sdata_out = sdata_out_q;
  assign fifo_count    = count_q;
  assign fifo_empty    = empty;
  assign fifo_full     = full;
  assign irq           = ~empty | overflow_q;

endmodule

// File: tb/tb_gpio_result_fifo.sv
// Scoreboard bench for gpio_result_fifo: bus reads queue their expected data, a monitor checks
// sdata_out after every read event; status outputs are checked directly by the stimulus.
module tb_gpio_result_fifo;

  localparam int unsigned DEPTH = 8;
  localparam logic [15:0] A_DATA = 16'h03B0;
  localparam logic [15:0] A_ONES = 16'h03B8;
  localparam logic [15:0] A_STAT = 16'h03C0;
  localparam logic [15:0] A_CTRL = 16'h03C8;

  logic clk;
  logic reset;
  logic [3:0] fifo_count;
  logic fifo_empty, fifo_full, irq;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  gpio_result_fifo_if bus_if ();

  gpio_result_fifo #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus_if.slave),
    .fifo_count (fifo_count),
    .fifo_empty (fifo_empty),
    .fifo_full  (fifo_full),
    .irq        (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every rising edge of srd is a read event; sdata_out is sampled 1 time unit later.
  initial begin
    logic prev;
    logic [31:0] e;
    prev = 1'b0;
    forever begin
      @(posedge clk);
      if (reset) begin
        prev = 1'b0;
      end else begin
        if (bus_if.srd && !prev) begin
          #1;
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL rd_unexpected: got %h expected no read", bus_if.sdata_out);
          end else begin
            e = exp_q.pop_front();
            if (bus_if.sdata_out !== e) begin
              errors++;
              $display("FAIL rd_data: got %h expected %h", bus_if.sdata_out, e);
            end
          end
        end
        prev = bus_if.srd;
      end
    end
  end

  task automatic bus_read(input logic [15:0] addr, input logic [31:0] exp);
    @(negedge clk);
    bus_if.saddress = addr;
    bus_if.srd      = 1'b1;
    exp_q.push_back(exp);
    @(negedge clk);
    bus_if.srd = 1'b0;
  endtask

  task automatic bus_write(input logic [15:0] addr, input logic [31:0] data);
    @(negedge clk);
    bus_if.saddress = addr;
    bus_if.sdata_in = data;
    bus_if.swr      = 1'b1;
    @(negedge clk);
    bus_if.swr = 1'b0;
  endtask

  task automatic push_res(input logic [31:0] w, input logic [5:0] o, input logic v);
    @(negedge clk);
    bus_if.done_pulse = 1'b1;
    bus_if.res_word   = w;
    bus_if.res_ones   = o;
    bus_if.res_valid  = v;
    @(negedge clk);
    bus_if.done_pulse = 1'b0;
  endtask

  initial begin
    reset             = 1'b1;
    bus_if.done_pulse = 1'b0;
    bus_if.res_word   = '0;
    bus_if.res_ones   = '0;
    bus_if.res_valid  = 1'b0;
    bus_if.saddress   = '0;
    bus_if.srd        = 1'b0;
    bus_if.swr        = 1'b0;
    bus_if.sdata_in   = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Reset state
    check("rst_count", 32'(fifo_count), 32'd0);
    check("rst_empty", 32'(fifo_empty), 32'd1);
    check("rst_full", 32'(fifo_full), 32'd0);
    check("rst_irq", 32'(irq), 32'd0);
    check("rst_sdata", bus_if.sdata_out, 32'd0);
    bus_read(A_STAT, 32'h0000_0010);
    bus_read(A_ONES, 32'h0);
    check("empty_pop_count", 32'(fifo_count), 32'd0);

    // Three results, peek and pop
    push_res(32'h0000_0006, 6'd2, 1'b1);
    push_res(32'hFFFF_FFFF, 6'd32, 1'b0);
    push_res(32'h0000_0001, 6'd1, 1'b1);
    check("three_count", 32'(fifo_count), 32'd3);
    check("three_irq", 32'(irq), 32'd1);
    bus_read(A_DATA, 32'h0000_0006);
    bus_read(A_DATA, 32'h0000_0006);
    bus_read(A_ONES, 32'h0000_0042);
    bus_read(A_DATA, 32'hFFFF_FFFF);
    bus_read(A_ONES, 32'h0000_0020);
    bus_read(A_DATA, 32'h0000_0001);
    bus_read(A_ONES, 32'h0000_0041);
    check("three_drained", 32'(fifo_empty), 32'd1);
    bus_read(A_DATA, 32'h0);
    bus_read(16'h0000, 32'h0);

    // Overflow: ten pushes into eight entries
    for (int i = 0; i < 10; i++) push_res(32'h100 + 32'(i), 6'(i), i[0]);
    check("ovf_full", 32'(fifo_full), 32'd1);
    check("ovf_count", 32'(fifo_count), 32'd8);
    bus_read(A_STAT, 32'h0000_0268);
    for (int i = 0; i < 8; i++) begin
      bus_read(A_DATA, 32'h100 + 32'(i));
      bus_read(A_ONES, {25'b0, i[0], 6'(i)});
    end
    bus_read(A_STAT, 32'h0000_0250);
    check("ovf_irq_sticky", 32'(irq), 32'd1);
    bus_write(A_CTRL, 32'h2);
    bus_read(A_STAT, 32'h0000_0010);
    check("clr_irq", 32'(irq), 32'd0);

    // Full FIFO: push and pop in the same cycle
    for (int i = 0; i < 8; i++) push_res(32'h200 + 32'(i), 6'(i), 1'b1);
    @(negedge clk);
    bus_if.done_pulse = 1'b1;
    bus_if.res_word   = 32'hABCD_0001;
    bus_if.res_ones   = 6'd7;
    bus_if.res_valid  = 1'b0;
    bus_if.saddress   = A_ONES;
    bus_if.srd        = 1'b1;
    exp_q.push_back(32'h0000_0040);
    @(negedge clk);
    bus_if.done_pulse = 1'b0;
    bus_if.srd        = 1'b0;
    check("pushpop_count", 32'(fifo_count), 32'd8);
    bus_read(A_STAT, 32'h0000_0028);
    for (int i = 1; i < 8; i++) bus_read(A_ONES, 32'h40 + 32'(i));
    bus_read(A_DATA, 32'hABCD_0001);
    bus_read(A_ONES, 32'h0000_0007);
    check("pushpop_empty", 32'(fifo_empty), 32'd1);

    // Flush with a coincident done_pulse
    for (int i = 0; i < 5; i++) push_res(32'h300 + 32'(i), 6'(i), 1'b1);
    @(negedge clk);
    bus_if.saddress   = A_CTRL;
    bus_if.sdata_in   = 32'h1;
    bus_if.swr        = 1'b1;
    bus_if.done_pulse = 1'b1;
    bus_if.res_word   = 32'hDEAD_BEEF;
    @(negedge clk);
    bus_if.swr        = 1'b0;
    bus_if.done_pulse = 1'b0;
    check("flush_count", 32'(fifo_count), 32'd0);
    check("flush_empty", 32'(fifo_empty), 32'd1);
    bus_read(A_STAT, 32'h0000_0010);

    // Held read strobe pops exactly once
    for (int i = 0; i < 3; i++) push_res(32'h400 + 32'(i), 6'(i), 1'b1);
    @(negedge clk);
    bus_if.saddress = A_ONES;
    bus_if.srd      = 1'b1;
    exp_q.push_back(32'h0000_0040);
    repeat (10) @(negedge clk);
    bus_if.srd = 1'b0;
    check("held_srd_count", 32'(fifo_count), 32'd2);
    bus_read(A_DATA, 32'h0000_0401);
    bus_read(A_ONES, 32'h0000_0041);
    bus_read(A_ONES, 32'h0000_0042);

    // Asynchronous reset with four entries and overflow set
    for (int i = 0; i < 9; i++) push_res(32'h500 + 32'(i), 6'(i), 1'b1);
    for (int i = 0; i < 4; i++) bus_read(A_ONES, 32'h40 + 32'(i));
    bus_read(A_STAT, 32'h0000_0144);
    bus_read(A_DATA, 32'h0000_0504);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("arst_count", 32'(fifo_count), 32'd0);
    check("arst_empty", 32'(fifo_empty), 32'd1);
    check("arst_full", 32'(fifo_full), 32'd0);
    check("arst_irq", 32'(irq), 32'd0);
    check("arst_sdata", bus_if.sdata_out, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    bus_read(A_STAT, 32'h0000_0010);
    push_res(32'hCAFE_F00D, 6'd24, 1'b1);
    check("post_rst_count", 32'(fifo_count), 32'd1);
    bus_read(A_DATA, 32'hCAFE_F00D);
    bus_read(A_ONES, 32'h0000_0058);
    check("post_rst_empty", 32'(fifo_empty), 32'd1);

    repeat (3) @(negedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
